// File: rtl/dec_pkg.sv
// Shared state type and helpers for the sequential N-to-M one-hot decoder.
package dec_pkg;

  localparam int unsigned MAX_SEL_W = 6;
  localparam int unsigned MAX_OUTS  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } dec_state_t;

  // Widest one-hot vector; callers truncate to their own OUTS.
  function automatic logic [MAX_OUTS-1:0] onehot_of(input logic [MAX_SEL_W-1:0] idx);
    return MAX_OUTS'(1) << idx;
  endfunction

  // Divider width able to hold 0..scan_div.
  function automatic int unsigned div_w(input int unsigned scan_div);
    return $clog2(scan_div + 1);
  endfunction

endpackage

// File: rtl/dec_scan_tick.sv
// Scan-rate divider: tick pulses on the last of every SCAN_DIV running cycles.
module dec_scan_tick
  import dec_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      DIV_W = div_w(SCAN_DIV);
  localparam logic [DIV_W-1:0] TERM  = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = run && !clr && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/n_to_m_decoder_seq.sv
// Registered SEL_W-to-OUTS one-hot decoder with handshake DECODE and autonomous SCAN modes.
// Define DEC_RANGE_CHK_EN to add the sticky err output for out-of-range codes.
module n_to_m_decoder_seq
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned OUTS     = 8,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [OUTS-1:0]  onehot,
  output logic [SEL_W-1:0] idx
`ifdef DEC_RANGE_CHK_EN
  ,
  output logic             err
`endif
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUTS - 1);

  dec_state_t       state;
  dec_state_t       state_nxt;
  logic [OUTS-1:0]  onehot_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic [SEL_W-1:0] scan_idx;
  logic             accept;
  logic             in_range;
  logic             scan_run;
  logic             scan_clr;
  logic             scan_tick;

  function automatic logic [OUTS-1:0] dec_of(input logic [SEL_W-1:0] code);
    return OUTS'(onehot_of(MAX_SEL_W'(code)));
  endfunction

  assign sel_ready = (state == DECODE) && enable && !mode;
  assign accept    = sel_valid && sel_ready;
  assign in_range  = 32'(sel) < OUTS;
  assign scan_run  = (state == SCAN) && enable && mode;
  assign scan_idx  = (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);

  dec_scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (scan_run),
    .clr  (scan_clr),
    .tick (scan_tick)
  );

  // Next state and next output values; enable=0 overrides everything.
  always_comb begin
    state_nxt  = state;
    onehot_nxt = onehot;
    idx_nxt    = idx;
    scan_clr   = 1'b0;
    if (!enable) begin
      state_nxt  = IDLE;
      onehot_nxt = '0;
      idx_nxt    = '0;
      scan_clr   = 1'b1;
    end else begin
      case (state)
        IDLE, DECODE: begin
          if (mode) begin
            state_nxt  = SCAN;
            onehot_nxt = OUTS'(1);
            idx_nxt    = '0;
            scan_clr   = 1'b1;
          end else begin
            state_nxt = DECODE;
            if (accept) begin
              onehot_nxt = in_range ? dec_of(sel) : '0;
              idx_nxt    = in_range ? sel : '0;
            end
          end
        end
        SCAN: begin
          if (!mode) begin
            state_nxt = DECODE;
          end else if (scan_tick) begin
            idx_nxt    = scan_idx;
            onehot_nxt = dec_of(scan_idx);
          end
        end
        default: begin
          state_nxt  = IDLE;
          onehot_nxt = '0;
          idx_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      onehot <= '0;
      idx    <= '0;
    end else begin
      state  <= state_nxt;
      onehot <= onehot_nxt;
      idx    <= idx_nxt;
    end
  end

`ifdef DEC_RANGE_CHK_EN
  // Sticky out-of-range flag, cleared by an in-range accept or by enable=0.
  logic err_nxt;

  always_comb begin
    err_nxt = err;
    if (!enable) begin
      err_nxt = 1'b0;
    end else if (accept) begin
      err_nxt = !in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_n_to_m_decoder_seq.sv
// Directed bench for n_to_m_decoder_seq: three instances (8 outs, 6 outs, 5 outs) share stimulus.
module tb_n_to_m_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       mode;
  logic       sel_valid;
  logic [2:0] sel;

  logic       rdy8, rdy6, rdy5;
  logic [7:0] oh8;
  logic [5:0] oh6;
  logic [4:0] oh5;
  logic [2:0] idx8, idx6, idx5;
`ifdef DEC_RANGE_CHK_EN
  logic       err8, err6, err5;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  n_to_m_decoder_seq #(.SEL_W(3), .OUTS(8), .SCAN_DIV(4)) u_dec8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel_valid(sel_valid),
    .sel_ready(rdy8), .sel(sel), .onehot(oh8), .idx(idx8)
`ifdef DEC_RANGE_CHK_EN
    , .err(err8)
`endif
  );

  n_to_m_decoder_seq #(.SEL_W(3), .OUTS(6), .SCAN_DIV(1)) u_dec6 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel_valid(sel_valid),
    .sel_ready(rdy6), .sel(sel), .onehot(oh6), .idx(idx6)
`ifdef DEC_RANGE_CHK_EN
    , .err(err6)
`endif
  );

  n_to_m_decoder_seq #(.SEL_W(3), .OUTS(5), .SCAN_DIV(3)) u_dec5 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel_valid(sel_valid),
    .sel_ready(rdy5), .sel(sel), .onehot(oh5), .idx(idx5)
`ifdef DEC_RANGE_CHK_EN
    , .err(err5)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nvec++;
    if ({rdy8, idx8, oh8} !== 12'h000) begin
      nerr++; $display("FAIL reset_dec8 got rdy=%b idx=%0d oh=%b exp 0/0/0", rdy8, idx8, oh8);
    end
    nvec++;
    if ({rdy6, idx6, oh6} !== 10'h000) begin
      nerr++; $display("FAIL reset_dec6 got rdy=%b idx=%0d oh=%b exp 0/0/0", rdy6, idx6, oh6);
    end
    nvec++;
    if ({rdy5, idx5, oh5} !== 9'h000) begin
      nerr++; $display("FAIL reset_dec5 got rdy=%b idx=%0d oh=%b exp 0/0/0", rdy5, idx5, oh5);
    end
`ifdef DEC_RANGE_CHK_EN
    nvec++;
    if ({err8, err6, err5} !== 3'b000) begin
      nerr++; $display("FAIL reset_err got=%b%b%b exp=000", err8, err6, err5);
    end
`endif
  endtask

  task automatic test_decode();
    logic [7:0] e8;
    enable = 1'b1; mode = 1'b0; sel_valid = 1'b0; sel = 3'd0;
    nvec++;
    if (rdy8 !== 1'b0) begin
      nerr++; $display("FAIL idle_ready got=%b exp=0", rdy8);
    end
    step();
    nvec++;
    if (rdy8 !== 1'b1) begin
      nerr++; $display("FAIL decode_ready got=%b exp=1", rdy8);
    end
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i); sel_valid = 1'b1;
      step();
      e8 = 8'b1 << i;
      nvec++;
      if (oh8 !== e8 || idx8 !== 3'(i)) begin
        nerr++; $display("FAIL decode8 code=%0d got oh=%b idx=%0d exp oh=%b idx=%0d", i, oh8, idx8, e8, i);
      end
    end
    sel_valid = 1'b0; sel = 3'd3;
    nvec++;
    if (rdy8 !== 1'b1) begin
      nerr++; $display("FAIL ready_no_valid got=%b exp=1", rdy8);
    end
    step();
    nvec++;
    if (oh8 !== 8'h80 || idx8 !== 3'd7) begin
      nerr++; $display("FAIL decode8_hold got oh=%b idx=%0d exp oh=10000000 idx=7", oh8, idx8);
    end
  endtask

  task automatic test_range();
    sel = 3'd5; sel_valid = 1'b1;
    step();
    nvec++;
    if (oh6 !== 6'b100000 || idx6 !== 3'd5) begin
      nerr++; $display("FAIL range_sel5 got oh=%b idx=%0d exp oh=100000 idx=5", oh6, idx6);
    end
    sel = 3'd6;
    step();
    nvec++;
    if (oh6 !== 6'b000000 || idx6 !== 3'd0) begin
      nerr++; $display("FAIL range_sel6 got oh=%b idx=%0d exp oh=000000 idx=0", oh6, idx6);
    end
`ifdef DEC_RANGE_CHK_EN
    nvec++;
    if (err6 !== 1'b1) begin
      nerr++; $display("FAIL range_err_set got=%b exp=1", err6);
    end
`endif
    sel_valid = 1'b0; sel = 3'd1;
    step();
    nvec++;
    if (oh6 !== 6'b000000) begin
      nerr++; $display("FAIL range_hold got oh=%b exp=000000", oh6);
    end
`ifdef DEC_RANGE_CHK_EN
    nvec++;
    if (err6 !== 1'b1) begin
      nerr++; $display("FAIL range_err_sticky got=%b exp=1", err6);
    end
`endif
    sel = 3'd2; sel_valid = 1'b1;
    step();
    nvec++;
    if (oh6 !== 6'b000100 || idx6 !== 3'd2) begin
      nerr++; $display("FAIL range_sel2 got oh=%b idx=%0d exp oh=000100 idx=2", oh6, idx6);
    end
`ifdef DEC_RANGE_CHK_EN
    nvec++;
    if (err6 !== 1'b0) begin
      nerr++; $display("FAIL range_err_clear got=%b exp=0", err6);
    end
`endif
    sel = 3'd7;
    step();
    sel_valid = 1'b0; enable = 1'b0;
    step();
    nvec++;
    if (oh6 !== 6'b000000 || idx6 !== 3'd0 || rdy6 !== 1'b0) begin
      nerr++; $display("FAIL range_disable got oh=%b idx=%0d rdy=%b exp 000000/0/0", oh6, idx6, rdy6);
    end
`ifdef DEC_RANGE_CHK_EN
    nvec++;
    if (err6 !== 1'b0) begin
      nerr++; $display("FAIL range_err_disable got=%b exp=0", err6);
    end
`endif
    enable = 1'b1;
    step();
  endtask

  task automatic test_scan();
    logic [2:0] e5, e6, e8;
    logic [4:0] eo5;
    logic [5:0] eo6;
    logic [7:0] eo8;
    mode = 1'b1; sel_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      step();
      e5 = 3'((k / 3) % 5); eo5 = 5'b1 << e5;
      e6 = 3'(k % 6);       eo6 = 6'b1 << e6;
      e8 = 3'((k / 4) % 8); eo8 = 8'b1 << e8;
      nvec++;
      if (idx5 !== e5 || oh5 !== eo5 || rdy5 !== 1'b0) begin
        nerr++; $display("FAIL scan5 k=%0d got idx=%0d oh=%b rdy=%b exp idx=%0d oh=%b rdy=0", k, idx5, oh5, rdy5, e5, eo5);
      end
      nvec++;
      if (idx6 !== e6 || oh6 !== eo6) begin
        nerr++; $display("FAIL scan6_div1 k=%0d got idx=%0d oh=%b exp idx=%0d oh=%b", k, idx6, oh6, e6, eo6);
      end
      nvec++;
      if (idx8 !== e8 || oh8 !== eo8) begin
        nerr++; $display("FAIL scan8 k=%0d got idx=%0d oh=%b exp idx=%0d oh=%b", k, idx8, oh8, e8, eo8);
      end
    end
  endtask

  task automatic test_mode_switch();
    enable = 1'b0;
    step();
    nvec++;
    if (oh5 !== 5'b00000 || idx5 !== 3'd0) begin
      nerr++; $display("FAIL scan_disable got oh=%b idx=%0d exp 00000/0", oh5, idx5);
    end
    enable = 1'b1; mode = 1'b1;
    for (int k = 0; k < 10; k++) step();
    nvec++;
    if (idx5 !== 3'd3 || oh5 !== 5'b01000) begin
      nerr++; $display("FAIL scan_reach3 got idx=%0d oh=%b exp idx=3 oh=01000", idx5, oh5);
    end
    mode = 1'b0;
    step();
    nvec++;
    if (oh5 !== 5'b01000 || idx5 !== 3'd3 || rdy5 !== 1'b1) begin
      nerr++; $display("FAIL switch_hold got oh=%b idx=%0d rdy=%b exp 01000/3/1", oh5, idx5, rdy5);
    end
    enable = 1'b0;
    #1;
    nvec++;
    if (rdy5 !== 1'b0) begin
      nerr++; $display("FAIL ready_disable got=%b exp=0", rdy5);
    end
    step();
    nvec++;
    if (oh5 !== 5'b00000 || idx5 !== 3'd0) begin
      nerr++; $display("FAIL switch_disable got oh=%b idx=%0d exp 00000/0", oh5, idx5);
    end
    enable = 1'b1;
    #1;
    nvec++;
    if (rdy5 !== 1'b0) begin
      nerr++; $display("FAIL idle_after_disable got rdy=%b exp=0", rdy5);
    end
    step();
    nvec++;
    if (rdy5 !== 1'b1) begin
      nerr++; $display("FAIL reenter_decode got rdy=%b exp=1", rdy5);
    end
  endtask

  task automatic test_handshake_hold();
    logic [2:0] e5;
    mode = 1'b1; sel_valid = 1'b1; sel = 3'd2;
    for (int k = 0; k < 6; k++) begin
      step();
      e5 = 3'((k / 3) % 5);
      nvec++;
      if (idx5 !== e5 || rdy5 !== 1'b0) begin
        nerr++; $display("FAIL hold_scan k=%0d got idx=%0d rdy=%b exp idx=%0d rdy=0", k, idx5, rdy5, e5);
      end
    end
    mode = 1'b0;
    step();
    nvec++;
    if (idx5 !== 3'd1 || oh5 !== 5'b00010 || rdy5 !== 1'b1) begin
      nerr++; $display("FAIL hold_first_decode got idx=%0d oh=%b rdy=%b exp 1/00010/1", idx5, oh5, rdy5);
    end
    step();
    nvec++;
    if (idx5 !== 3'd2 || oh5 !== 5'b00100) begin
      nerr++; $display("FAIL hold_accept got idx=%0d oh=%b exp 2/00100", idx5, oh5);
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 1'b1;
    for (int k = 0; k < 4; k++) step();
    @(posedge clk);
    #1;
    nvec++;
    if (idx5 !== 3'd1 || oh5 !== 5'b00010) begin
      nerr++; $display("FAIL prereset_scan got idx=%0d oh=%b exp 1/00010", idx5, oh5);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({rdy5, idx5, oh5} !== 9'h000 || {rdy8, idx8, oh8} !== 12'h000 || {rdy6, idx6, oh6} !== 10'h000) begin
      nerr++; $display("FAIL async_reset got oh5=%b idx5=%0d rdy5=%b oh8=%b oh6=%b exp all zero", oh5, idx5, rdy5, oh8, oh6);
    end
`ifdef DEC_RANGE_CHK_EN
    nvec++;
    if ({err8, err6, err5} !== 3'b000) begin
      nerr++; $display("FAIL async_reset_err got=%b%b%b exp=000", err8, err6, err5);
    end
`endif
    #2;
    rst_n = 1'b1;
    step();
    nvec++;
    if (idx5 !== 3'd0 || oh5 !== 5'b00001) begin
      nerr++; $display("FAIL post_reset_scan got idx=%0d oh=%b exp 0/00001", idx5, oh5);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = 3'd0;
    #12;
    test_reset();
    rst_n = 1'b1;
    test_decode();
    test_range();
    test_scan();
    test_mode_switch();
    test_handshake_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
